scon_bank: RTL and testbench
============================

Name: scon_bank

Overview:
- Parametrised multi-channel successor to the single SCON register. Holds NUM_CH 8051-style SCON registers plus one status register per channel, all behind a simple CPU register port.
- Adds behaviour the single register lacks:
  - sticky TI/RI flags that only software clears;
  - SM2 multiprocessor address filtering;
  - REN-gated reception;
  - RB8 latching;
  - overrun detection;
  - per-channel interrupt enable.
- Sits between the CPU SFR bus and NUM_CH UART datapaths.

Parameters:
- NUM_CH, 4, number of serial channels (1..8).
- ADDR_W, 4, CPU address width; must satisfy 2**ADDR_W >= 2*NUM_CH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  ADDR_W  register address: 2*ch = SCON[ch], 2*ch+1 = STAT[ch].
- cpu_wr  in  1  write strobe, one cycle.
- cpu_rd  in  1  read strobe, one cycle.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data, registered.
- tx_complete  in  NUM_CH  per-channel one-cycle pulse; sets TI.
- rx_complete  in  NUM_CH  per-channel one-cycle pulse; candidate RI set.
- rb8_in  in  NUM_CH  received 9th bit, qualified by rx_complete.
- sm_mode  out  2*NUM_CH  {SM0,SM1} per channel; ch0 in bits [1:0].
- ren  out  NUM_CH  REN per channel.
- tb8  out  NUM_CH  TB8 per channel.
- irq  out  NUM_CH  per-channel interrupt.
- irq_any  out  1  OR of irq.

Behaviour:
- SCON bit map: 7 SM0, 6 SM1, 5 SM2, 4 REN, 3 TB8, 2 RB8, 1 TI, 0 RI.
- STAT bit map: 7 IE (R/W), 1 IRQ (RO, = irq[ch]), 0 OVR (write-1-to-clear); other bits read 0, writes ignored.
- Reset: every SCON and STAT cleared to 0x00; cpu_rdata = 0x00; all outputs 0. rx_complete and tx_complete asserted during reset are ignored.
- CPU write to SCON (takes effect next cycle): all 8 bits are written, including TI and RI, so software can set or clear them.
- CPU read:
  - cpu_rdata updates on the clock edge where cpu_rd = 1 (1-cycle latency) and holds otherwise.
  - A read returns the pre-update register value from the same cycle.
  - cpu_rd together with cpu_wr to the same address reads the old value.
- Out-of-range address (>= 2*NUM_CH): write ignored, read returns 0x00.
- Accepted rx: rx_complete[ch] & REN & !(SM0 & SM2 & !rb8_in). SM2 filtering applies only in modes 2 and 3; SM2 is ignored in modes 0 and 1. Non-accepted pulses change nothing.
- On accepted rx:
  - RI <= 1.
  - RB8 <= rb8_in in modes 1, 2 and 3; unchanged in mode 0.
  - If RI was already 1 and no same-cycle software clear of RI, OVR <= 1.
- On tx_complete: TI <= 1 regardless of mode or REN.
- Simultaneous events:
  - Hardware set of TI, RI, RB8 or OVR beats a same-cycle CPU write of the opposite value.
  - A software write of 0 to RI in the same cycle as an accepted rx leaves RI = 1 and OVR unchanged.
  - A W1C on OVR in the same cycle as a new overrun leaves OVR = 1.
- irq[ch] = IE & (TI | RI), combinational from the flops, so it is visible the cycle after the setting event. irq_any = |irq.
- Outputs sm_mode, ren and tb8 are direct flop outputs, updated the cycle after the write.
- Channels are fully independent; no cross-channel priority.

Decomposition:
- Package scon_pkg:
  - bit-index constants: SM0_B, SM1_B, SM2_B, REN_B, TB8_B, RB8_B, TI_B, RI_B, IE_B, OVR_B;
  - address offsets SCON_OFS = 0, STAT_OFS = 1;
  - mode enum MODE0_SHIFT, MODE1_8BIT, MODE2_9BIT_FIXED, MODE3_9BIT_VAR.
- Sub-module scon_channel holds one SCON/STAT pair and its flag logic. It takes a decoded write-enable, wdata and the hardware pulses, and outputs both registers and irq.
- scon_bank instantiates NUM_CH scon_channel copies via generate and contains the address decode and the registered read mux.

Test Plan:
- Reset, then read all 2*NUM_CH addresses -> every read 0x00; irq_any = 0.
- Write SCON[1] = 0x50 (mode 1, REN), pulse rx_complete[1] with rb8_in = 1 -> SCON[1] reads 0x55; STAT[1].OVR = 0; irq[1] = 0 until STAT[1] written 0x80, then irq[1] = 1.
- SCON[2] = 0xF0 (mode 3, SM2, REN): rx with rb8_in = 0 -> SCON[2] unchanged at 0xF0; rx with rb8_in = 1 -> SCON[2] reads 0xF5.
- With RI[0] = 1, pulse rx_complete[0] -> STAT[0] reads 0x01. Write STAT[0] = 0x01 in the same cycle as another accepted rx -> OVR stays 1. Repeat the write with no rx -> OVR clears.
- In the same cycle, CPU writes SCON[3] = 0x00 and tx_complete[3] pulses -> SCON[3] reads 0x02.
- REN = 0 on channel 0, pulse rx_complete[0] -> SCON[0] unchanged. Assert reset while pulsing tx_complete on all channels -> all registers read 0x00 after reset.

Source files
------------

// File: rtl/scon_pkg.sv
// Shared definitions for the multi-channel SCON register bank:
// SCON/STAT bit positions, register address offsets and serial mode encoding.
package scon_pkg;

  localparam int SM0_B = 7;
  localparam int SM1_B = 6;
  localparam int SM2_B = 5;
  localparam int REN_B = 4;
  localparam int TB8_B = 3;
  localparam int RB8_B = 2;
  localparam int TI_B  = 1;
  localparam int RI_B  = 0;

  localparam int IE_B  = 7;
  localparam int IRQ_B = 1;
  localparam int OVR_B = 0;

  localparam logic SCON_OFS = 1'b0;
  localparam logic STAT_OFS = 1'b1;

  typedef enum logic [1:0] {
    MODE0_SHIFT      = 2'd0,
    MODE1_8BIT       = 2'd1,
    MODE2_9BIT_FIXED = 2'd2,
    MODE3_9BIT_VAR   = 2'd3
  } mode_e;

endpackage

// File: rtl/scon_bank_if.sv
// CPU SFR register port of the SCON bank: address, one-cycle strobes and data.
interface scon_bank_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_wr;
  logic              cpu_rd;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;

  modport master (output cpu_addr, cpu_wr, cpu_rd, cpu_wdata, input cpu_rdata);
  modport slave  (input cpu_addr, cpu_wr, cpu_rd, cpu_wdata, output cpu_rdata);
endinterface

// File: rtl/scon_channel.sv
// One SCON/STAT register pair with sticky TI/RI, SM2 filtering, RB8 latch,
// overrun detection and interrupt enable.
module scon_channel
  import scon_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       scon_we,
  input  logic       stat_we,
  input  logic [7:0] wdata,
  input  logic       tx_complete,
  input  logic       rx_complete,
  input  logic       rb8_in,
  output logic [7:0] scon,
  output logic [7:0] stat,
  output logic       irq
);

  logic       ie;
  logic       ovr;
  logic [7:0] scon_n;
  logic       ie_n;
  logic       ovr_n;
  logic       accept;
  logic       sw_ri_clr;
  mode_e      mode;

  assign mode = mode_e'({scon[SM0_B], scon[SM1_B]});

  // SM2 only filters on the 9th bit in the 9-bit modes.
  assign accept = rx_complete & scon[REN_B] &
                  ~(((mode == MODE2_9BIT_FIXED) || (mode == MODE3_9BIT_VAR)) &
                    scon[SM2_B] & ~rb8_in);

  assign sw_ri_clr = scon_we & ~wdata[RI_B];

  // Hardware sets are applied after the CPU write so they win any collision.
  always_comb begin
    scon_n = scon_we ? wdata : scon;
    if (tx_complete) scon_n[TI_B] = 1'b1;
    if (accept) begin
      scon_n[RI_B] = 1'b1;
      if (mode != MODE0_SHIFT) scon_n[RB8_B] = rb8_in;
    end
  end

  always_comb begin
    ie_n  = stat_we ? wdata[IE_B] : ie;
    ovr_n = ovr;
    if (stat_we && wdata[OVR_B]) ovr_n = 1'b0;
    if (accept && scon[RI_B] && !sw_ri_clr) ovr_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scon <= '0;
      ie   <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      scon <= scon_n;
      ie   <= ie_n;
      ovr  <= ovr_n;
    end
  end

  assign irq  = ie & (scon[TI_B] | scon[RI_B]);
  assign stat = {ie, 5'b0, irq, ovr};

endmodule

// File: rtl/scon_bank.sv
// NUM_CH SCON/STAT channels behind one CPU register port with address decode
// and a registered read mux.
module scon_bank
  import scon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  scon_bank_if.slave          bus,
  input  logic [NUM_CH-1:0]   tx_complete,
  input  logic [NUM_CH-1:0]   rx_complete,
  input  logic [NUM_CH-1:0]   rb8_in,
  output logic [2*NUM_CH-1:0] sm_mode,
  output logic [NUM_CH-1:0]   ren,
  output logic [NUM_CH-1:0]   tb8,
  output logic [NUM_CH-1:0]   irq,
  output logic                irq_any
);

  logic              in_range;
  logic [ADDR_W-2:0] ch_sel;
  logic              is_stat;
  logic [7:0]        scon_r [NUM_CH];
  logic [7:0]        stat_r [NUM_CH];
  logic [7:0]        rd_mux;

  assign in_range = {{(32-ADDR_W){1'b0}}, bus.cpu_addr} < 32'(2*NUM_CH);
  assign ch_sel   = bus.cpu_addr[ADDR_W-1:1];
  assign is_stat  = bus.cpu_addr[0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = in_range & (ch_sel == (ADDR_W-1)'(i));

    scon_channel u_ch (
      .clk         (clk),
      .reset       (reset),
      .scon_we     (bus.cpu_wr & sel & (is_stat == SCON_OFS)),
      .stat_we     (bus.cpu_wr & sel & (is_stat == STAT_OFS)),
      .wdata       (bus.cpu_wdata),
      .tx_complete (tx_complete[i]),
      .rx_complete (rx_complete[i]),
      .rb8_in      (rb8_in[i]),
      .scon        (scon_r[i]),
      .stat        (stat_r[i]),
      .irq         (irq[i])
    );

    assign sm_mode[2*i +: 2] = {scon_r[i][SM0_B], scon_r[i][SM1_B]};
    assign ren[i]            = scon_r[i][REN_B];
    assign tb8[i]            = scon_r[i][TB8_B];
  end

  assign irq_any = |irq;

  always_comb begin
    rd_mux = '0;
    if (in_range) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_sel == (ADDR_W-1)'(c)) rd_mux = is_stat ? stat_r[c] : scon_r[c];
      end
    end
  end

  // Registers are sampled before this edge's update, so read-during-write returns the old value.
  always_ff @(posedge clk) begin
    if (reset) bus.cpu_rdata <= '0;
    else if (bus.cpu_rd) bus.cpu_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_scon_bank.sv
// Self-checking bench for scon_bank: directed scenarios plus randomized traffic
// against a register-level reference model.
module tb_scon_bank;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NUM_CH-1:0] tx_complete = '0;
  logic [NUM_CH-1:0] rx_complete = '0;
  logic [NUM_CH-1:0] rb8_in = '0;
  logic [2*NUM_CH-1:0] sm_mode;
  logic [NUM_CH-1:0] ren, tb8, irq;
  logic              irq_any;

  scon_bank_if #(.ADDR_W(ADDR_W)) bus ();

  scon_bank #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .tx_complete (tx_complete),
    .rx_complete (rx_complete),
    .rb8_in      (rb8_in),
    .sm_mode     (sm_mode),
    .ren         (ren),
    .tb8         (tb8),
    .irq         (irq),
    .irq_any     (irq_any)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: register contents as bytes plus IE and OVR per channel.
  logic [7:0] m_scon [NUM_CH];
  logic       m_ie   [NUM_CH];
  logic       m_ovr  [NUM_CH];
  logic [7:0] m_rdata;

  function automatic logic m_irq(input int ch);
    return m_ie[ch] && (m_scon[ch][1] || m_scon[ch][0]);
  endfunction

  function automatic logic [7:0] m_read(input int a);
    int ch;
    if (a >= 2*NUM_CH) return 8'h00;
    ch = a / 2;
    if (a % 2 == 1) return {m_ie[ch], 5'b0, m_irq(ch), m_ovr[ch]};
    return m_scon[ch];
  endfunction

  task automatic m_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_scon[c] = 8'h00;
      m_ie[c]   = 1'b0;
      m_ovr[c]  = 1'b0;
    end
    m_rdata = 8'h00;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, release strobes.
  task automatic step(input logic wr, input logic rd, input int a, input logic [7:0] wd,
                      input logic [NUM_CH-1:0] tx, input logic [NUM_CH-1:0] rx,
                      input logic [NUM_CH-1:0] rb8);
    logic [7:0] n_scon [NUM_CH];
    logic       n_ie   [NUM_CH];
    logic       n_ovr  [NUM_CH];
    bus.cpu_wr    = wr;
    bus.cpu_rd    = rd;
    bus.cpu_addr  = ADDR_W'(a);
    bus.cpu_wdata = wd;
    tx_complete   = tx;
    rx_complete   = rx;
    rb8_in        = rb8;
    for (int c = 0; c < NUM_CH; c++) begin
      int  mode;
      bit  acc;
      mode = m_scon[c] / 64;
      acc  = rx[c] && m_scon[c][4] && !(mode >= 2 && m_scon[c][5] && !rb8[c]);
      n_scon[c] = (wr && a == 2*c) ? wd : m_scon[c];
      n_ie[c]   = (wr && a == 2*c+1) ? wd[7] : m_ie[c];
      n_ovr[c]  = m_ovr[c];
      if (wr && a == 2*c+1 && wd[0]) n_ovr[c] = 1'b0;
      if (tx[c]) n_scon[c] = n_scon[c] | 8'h02;
      if (acc) begin
        n_scon[c] = n_scon[c] | 8'h01;
        if (mode != 0) n_scon[c] = (n_scon[c] & 8'hFB) | (rb8[c] ? 8'h04 : 8'h00);
        if (m_scon[c][0] && !(wr && a == 2*c && !wd[0])) n_ovr[c] = 1'b1;
      end
    end
    if (rd) m_rdata = m_read(a);
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      m_scon[c] = n_scon[c];
      m_ie[c]   = n_ie[c];
      m_ovr[c]  = n_ovr[c];
    end
    bus.cpu_wr  = 1'b0;
    bus.cpu_rd  = 1'b0;
    tx_complete = '0;
    rx_complete = '0;
    rb8_in      = '0;
  endtask

  task automatic wr_reg(input int a, input logic [7:0] d);
    step(1'b1, 1'b0, a, d, '0, '0, '0);
  endtask

  task automatic rd_reg(input int a, output logic [7:0] d);
    step(1'b0, 1'b1, a, 8'h00, '0, '0, '0);
    d = bus.cpu_rdata;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    tx_complete = '1;
    rx_complete = '1;
    rb8_in      = '1;
    repeat (2) @(posedge clk);
    #1;
    reset       = 1'b0;
    tx_complete = '0;
    rx_complete = '0;
    rb8_in      = '0;
    m_clear();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    total++;
    if (bus.cpu_rdata !== 8'h00) begin
      bad++; $display("FAIL reset_rdata got=%h exp=00", bus.cpu_rdata);
    end
    total++;
    if ({sm_mode, ren, tb8, irq, irq_any} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {sm_mode, ren, tb8, irq, irq_any});
    end
    for (int a = 0; a < 2*NUM_CH; a++) begin
      rd_reg(a, d);
      total++;
      if (d !== 8'h00) begin bad++; $display("FAIL reset_read[%0d] got=%h exp=00", a, d); end
    end
  endtask

  task automatic test_rx_mode1();
    logic [7:0] d;
    wr_reg(2, 8'h50);
    step(1'b0, 1'b0, 0, 8'h00, '0, 4'b0010, 4'b0010);
    rd_reg(2, d);
    total++;
    if (d !== 8'h55) begin bad++; $display("FAIL rx_mode1_scon got=%h exp=55", d); end
    rd_reg(3, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL rx_mode1_stat got=%h exp=00", d); end
    total++;
    if (irq[1] !== 1'b0) begin bad++; $display("FAIL rx_mode1_irq_off got=%b exp=0", irq[1]); end
    wr_reg(3, 8'h80);
    total++;
    if (irq[1] !== 1'b1 || irq_any !== 1'b1) begin
      bad++; $display("FAIL rx_mode1_irq_on got=%b/%b exp=1/1", irq[1], irq_any);
    end
    rd_reg(3, d);
    total++;
    if (d !== 8'h82) begin bad++; $display("FAIL rx_mode1_stat_ie got=%h exp=82", d); end
  endtask

  task automatic test_sm2_filter();
    logic [7:0] d;
    wr_reg(4, 8'hF0);
    step(1'b0, 1'b0, 0, 8'h00, '0, 4'b0100, 4'b0000);
    rd_reg(4, d);
    total++;
    if (d !== 8'hF0) begin bad++; $display("FAIL sm2_reject got=%h exp=F0", d); end
    step(1'b0, 1'b0, 0, 8'h00, '0, 4'b0100, 4'b0100);
    rd_reg(4, d);
    total++;
    if (d !== 8'hF5) begin bad++; $display("FAIL sm2_accept got=%h exp=F5", d); end
    // SM2 has no effect in mode 1
    wr_reg(4, 8'h70);
    step(1'b0, 1'b0, 0, 8'h00, '0, 4'b0100, 4'b0000);
    rd_reg(4, d);
    total++;
    if (d !== 8'h71) begin bad++; $display("FAIL sm2_mode1 got=%h exp=71", d); end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    wr_reg(0, 8'h10);
    step(1'b0, 1'b0, 0, 8'h00, '0, 4'b0001, 4'b0001);
    step(1'b0, 1'b0, 0, 8'h00, '0, 4'b0001, 4'b0001);
    rd_reg(1, d);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL ovr_set got=%h exp=01", d); end
    step(1'b1, 1'b0, 1, 8'h01, '0, 4'b0001, 4'b0000);
    rd_reg(1, d);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL ovr_w1c_collide got=%h exp=01", d); end
    wr_reg(1, 8'h01);
    rd_reg(1, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL ovr_w1c got=%h exp=00", d); end
    // clearing RI in the same cycle as a new rx keeps RI and does not flag overrun
    step(1'b1, 1'b0, 0, 8'h10, '0, 4'b0001, 4'b0000);
    rd_reg(0, d);
    total++;
    if (d !== 8'h11) begin bad++; $display("FAIL ri_clear_collide got=%h exp=11", d); end
    rd_reg(1, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL ri_clear_no_ovr got=%h exp=00", d); end
  endtask

  task automatic test_tx_collision();
    logic [7:0] d;
    step(1'b1, 1'b0, 6, 8'h00, 4'b1000, '0, '0);
    rd_reg(6, d);
    total++;
    if (d !== 8'h02) begin bad++; $display("FAIL tx_collide got=%h exp=02", d); end
  endtask

  task automatic test_ren_off_and_misc();
    logic [7:0] d;
    wr_reg(0, 8'h00);
    step(1'b0, 1'b0, 0, 8'h00, '0, 4'b0001, 4'b0001);
    rd_reg(0, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL ren_off got=%h exp=00", d); end
    wr_reg(0, 8'h5A);
    step(1'b1, 1'b1, 0, 8'hC3, '0, '0, '0);
    total++;
    if (bus.cpu_rdata !== 8'h5A) begin bad++; $display("FAIL rd_wr_same got=%h exp=5A", bus.cpu_rdata); end
    total++;
    if (sm_mode[1:0] !== 2'b11 || tb8[0] !== 1'b0 || ren[0] !== 1'b0) begin
      bad++; $display("FAIL ch0_outputs got=%b/%b/%b exp=11/0/0", sm_mode[1:0], tb8[0], ren[0]);
    end
    wr_reg(2*NUM_CH, 8'hFF);
    rd_reg(2*NUM_CH, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL out_of_range got=%h exp=00", d); end
    step(1'b0, 1'b0, 0, 8'h00, '0, '0, '0);
    total++;
    if (bus.cpu_rdata !== 8'h00) begin bad++; $display("FAIL rdata_hold got=%h exp=00", bus.cpu_rdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic       wr, rd;
      int         a;
      logic [7:0] wd;
      wr = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 1) == 0);
      a  = $urandom_range(0, 2*NUM_CH + 1);
      wd = 8'($urandom);
      step(wr, rd, a, wd, NUM_CH'($urandom & $urandom), NUM_CH'($urandom),
           NUM_CH'($urandom));
      total++;
      if (bus.cpu_rdata !== m_rdata) begin
        bad++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", n, bus.cpu_rdata, m_rdata);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        total++;
        if (irq[c] !== m_irq(c) || sm_mode[2*c +: 2] !== m_scon[c][7:6] ||
            ren[c] !== m_scon[c][4] || tb8[c] !== m_scon[c][3]) begin
          bad++;
          $display("FAIL rand_out[%0d] ch%0d got=%b%b%b%b exp=%b%b%b%b", n, c, irq[c],
                   sm_mode[2*c +: 2], ren[c], tb8[c], m_irq(c), m_scon[c][7:6],
                   m_scon[c][4], m_scon[c][3]);
        end
      end
    end
  endtask

  task automatic test_reset_pulses();
    logic [7:0] d;
    for (int a = 0; a < 2*NUM_CH; a += 2) wr_reg(a, 8'hFF);
    for (int a = 1; a < 2*NUM_CH; a += 2) wr_reg(a, 8'h80);
    do_reset();
    for (int a = 0; a < 2*NUM_CH; a++) begin
      rd_reg(a, d);
      total++;
      if (d !== 8'h00) begin bad++; $display("FAIL reset_pulses[%0d] got=%h exp=00", a, d); end
    end
    total++;
    if (irq_any !== 1'b0) begin bad++; $display("FAIL reset_pulses_irq got=%b exp=0", irq_any); end
  endtask

  initial begin
    bus.cpu_addr  = '0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wdata = '0;
    m_clear();
    #1;
    test_reset();
    test_rx_mode1();
    test_sm2_filter();
    test_overrun();
    test_tx_collision();
    test_ren_off_and_misc();
    test_random();
    test_reset_pulses();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
